// File: rtl/snoopy_bus_ctrl.sv
// rtl/snoopy_bus_ctrl.sv - snoop bus controller: round-robin grant, snoop broadcast, response collection with timeout
module snoopy_bus_ctrl #(
    parameter int NCORES = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TMO    = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCORES-1:0]          req_valid,
    input  logic [NCORES-1:0]          req_wnr,
    input  logic [NCORES*AW-1:0]       req_addr,
    output logic                       snoop_valid,
    output logic                       snoop_wnr,
    output logic [AW-1:0]              snoop_addr,
    output logic [$clog2(NCORES)-1:0]  snoop_src,
    input  logic [NCORES-1:0]          snp_done,
    input  logic [NCORES-1:0]          snp_hit,
    input  logic [NCORES*DW-1:0]       snp_data,
    output logic [NCORES-1:0]          rsp_valid,
    output logic                       rsp_hit,
    output logic [DW-1:0]              rsp_data,
    output logic                       rsp_err
);
    localparam int SW = $clog2(NCORES);

    typedef enum logic [1:0] {IDLE, BCAST, RESP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] rr_q, rr_d;
    logic [SW-1:0] src_q, src_d;
    logic          wnr_q, wnr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;

    logic [SW-1:0]     grant;
    logic              found;
    logic [NCORES-1:0] src_oh;
    logic [NCORES-1:0] peer_hit;
    logic [DW-1:0]     peer_data;
    logic              complete;
    logic              timeout;
    logic [SW-1:0]     next_rr;

    always_comb begin
        grant = rr_q;
        found = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            if (!found && req_valid[(int'(rr_q) + k) % NCORES]) begin
                found = 1'b1;
                grant = SW'((int'(rr_q) + k) % NCORES);
            end
        end
    end

    always_comb begin
        src_oh         = '0;
        src_oh[src_q]  = 1'b1;
        peer_hit       = snp_hit & snp_done & ~src_oh;
        peer_data      = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (peer_hit[i]) begin
                peer_data = snp_data[i*DW +: DW];
            end
        end
        // Done levels are not trusted in the first broadcast cycle: caches need a cycle to see the snoop.
        complete = (&(snp_done | src_oh)) && (cnt_q != 8'd0);
        timeout  = (cnt_q == 8'(TMO - 1));
        next_rr  = (src_q == SW'(NCORES - 1)) ? '0 : src_q + SW'(1);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        wnr_d   = wnr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d = BCAST;
                    src_d   = grant;
                    wnr_d   = req_wnr[grant];
                    addr_d  = req_addr[int'(grant)*AW +: AW];
                    cnt_d   = '0;
                end
            end
            BCAST: begin
                cnt_d = cnt_q + 8'd1;
                if (complete) begin
                    state_d = RESP;
                    rr_d    = next_rr;
                    hit_d   = |peer_hit;
                    data_d  = wnr_q ? '0 : peer_data;
                    err_d   = 1'b0;
                end else if (timeout) begin
                    state_d = RESP;
                    rr_d    = next_rr;
                    hit_d   = 1'b0;
                    data_d  = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            src_q   <= '0;
            wnr_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            wnr_q   <= wnr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign snoop_valid = (state_q == BCAST);
    assign snoop_wnr   = wnr_q;
    assign snoop_addr  = addr_q;
    assign snoop_src   = src_q;
    assign rsp_valid   = (state_q == RESP) ? src_oh : '0;
    assign rsp_hit     = hit_q;
    assign rsp_data    = data_q;
    assign rsp_err     = err_q;

endmodule

// File: tb/tb_snoopy_bus_ctrl.sv
// tb/tb_snoopy_bus_ctrl.sv - directed scoreboard bench for snoopy_bus_ctrl with four cores
module tb_snoopy_bus_ctrl;
    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_wnr;
    logic [127:0] req_addr;
    logic         snoop_valid;
    logic         snoop_wnr;
    logic [31:0]  snoop_addr;
    logic [1:0]   snoop_src;
    logic [3:0]   snp_done;
    logic [3:0]   snp_hit;
    logic [127:0] snp_data;
    logic [3:0]   rsp_valid;
    logic         rsp_hit;
    logic [31:0]  rsp_data;
    logic         rsp_err;

    snoopy_bus_ctrl #(.NCORES(4), .AW(32), .DW(32), .TMO(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wnr(req_wnr), .req_addr(req_addr),
        .snoop_valid(snoop_valid), .snoop_wnr(snoop_wnr),
        .snoop_addr(snoop_addr), .snoop_src(snoop_src),
        .snp_done(snp_done), .snp_hit(snp_hit), .snp_data(snp_data),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  src;
        logic        wnr;
        logic [31:0] addr;
        logic        hit;
        logic [31:0] data;
        logic        err;
        int          sv;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pre);
        chk({pre, "_snoop_valid"}, snoop_valid, 0);
        chk({pre, "_snoop_wnr"},   snoop_wnr,   0);
        chk({pre, "_snoop_addr"},  snoop_addr,  0);
        chk({pre, "_snoop_src"},   snoop_src,   0);
        chk({pre, "_rsp_valid"},   rsp_valid,   0);
        chk({pre, "_rsp_hit"},     rsp_hit,     0);
        chk({pre, "_rsp_data"},    rsp_data,    0);
        chk({pre, "_rsp_err"},     rsp_err,     0);
    endtask

    // Expected outcome from the current cache stimulus; base is the number of
    // bench cycles spent in IDLE before the granting edge.
    task automatic expect_txn(input int src, input int base);
        exp_t       e;
        logic [3:0] peers;
        peers  = 4'b1111 & ~(4'b0001 << src);
        e.src  = 2'(src);
        e.wnr  = req_wnr[src];
        e.addr = req_addr[src*32 +: 32];
        e.sv   = base + 1;
        e.data = '0;
        if ((snp_done & peers) != peers) begin
            e.err = 1'b1;
            e.hit = 1'b0;
            e.lat = base + 16;
        end else begin
            e.err = 1'b0;
            e.hit = |(snp_hit & peers);
            if (!e.wnr) begin
                for (int i = 3; i >= 0; i--) begin
                    if (snp_hit[i] && peers[i]) e.data = snp_data[i*32 +: 32];
                end
            end
            e.lat = base + 3;
        end
        sb.push_back(e);
    endtask

    task automatic run_one(input bit drop_early, input int late_c);
        exp_t       e;
        int         lat;
        int         sv_at;
        logic [3:0] exp_oh;
        if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
            return;
        end
        e     = sb.pop_front();
        lat   = 0;
        sv_at = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (snoop_valid) begin
                if (sv_at == 0) begin
                    sv_at = c;
                    chk("snoop_src", snoop_src, e.src);
                    chk("snoop_addr", snoop_addr, e.addr);
                    if (drop_early) req_valid[e.src] = 1'b0;
                end
                chk("snoop_wnr", snoop_wnr, e.wnr);
            end
            if (c == late_c) snp_done = 4'b1111;
            if (rsp_valid != 4'b0000) lat = c;
        end
        exp_oh = 4'b0001 << e.src;
        chk("rsp_seen", lat != 0, 1);
        chk("snoop_latency", sv_at, e.sv);
        chk("rsp_latency", lat, e.lat);
        chk("rsp_valid", rsp_valid, exp_oh);
        chk("snoop_valid_in_resp", snoop_valid, 0);
        chk("rsp_hit", rsp_hit, e.hit);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        req_valid[e.src] = 1'b0;
    endtask

    task automatic idle_step();
        @(posedge clk); #1;
        chk("rsp_valid_one_cycle", rsp_valid, 0);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_wnr   = 4'b0000;
        req_addr  = '0;
        snp_done  = 4'b1111;
        snp_hit   = 4'b0000;
        snp_data  = '0;
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h40;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        req_valid = 4'b0000;
        #2 rst = 1'b0;

        // Simultaneous requests from cores 0,1,3 with rr=0
        @(posedge clk); #1;
        snp_hit = 4'b0100;
        snp_data[2*32 +: 32] = 32'h22;
        req_valid = 4'b1011;
        expect_txn(0, 0);
        expect_txn(1, 1);
        expect_txn(3, 1);
        run_one(0, 0);
        run_one(0, 0);
        run_one(0, 0);
        idle_step();

        // Single core1 transaction moves rr to 2
        req_valid = 4'b0010;
        expect_txn(1, 0);
        run_one(0, 0);
        idle_step();

        // Same three requesters with rr=2
        req_valid = 4'b1011;
        expect_txn(3, 0);
        expect_txn(0, 1);
        expect_txn(1, 1);
        run_one(0, 0);
        run_one(0, 0);
        run_one(0, 0);
        idle_step();

        // Core0 read at 0x100, core1 returns 0xCAFE0001; own hit of the requester is ignored
        req_addr[0 +: 32] = 32'h100;
        snp_hit = 4'b0011;
        snp_data[0 +: 32]  = 32'hDEAD0000;
        snp_data[32 +: 32] = 32'hCAFE0001;
        req_valid = 4'b0001;
        expect_txn(0, 0);
        run_one(0, 0);
        idle_step();
        chk("rsp_hit_hold", rsp_hit, 1);
        chk("rsp_data_hold", rsp_data, 32'hCAFE0001);

        // Core2 read, two hitters, requester's done held low, req dropped during broadcast
        snp_done = 4'b1011;
        snp_hit  = 4'b1010;
        snp_data[32 +: 32] = 32'h11;
        snp_data[96 +: 32] = 32'h33;
        req_valid = 4'b0100;
        expect_txn(2, 0);
        run_one(1, 0);
        idle_step();

        // Core1 write with no hits
        snp_done = 4'b1111;
        snp_hit  = 4'b0000;
        req_wnr  = 4'b1010;
        req_valid = 4'b0010;
        expect_txn(1, 0);
        run_one(0, 0);
        idle_step();

        // Core3 write with a hit: data must read back zero
        snp_hit = 4'b0001;
        snp_data[0 +: 32] = 32'h55;
        req_valid = 4'b1000;
        expect_txn(3, 0);
        run_one(0, 0);
        idle_step();

        // Core0 read, core1 never completes -> timeout
        snp_done = 4'b1101;
        snp_hit  = 4'b0100;
        req_valid = 4'b0001;
        expect_txn(0, 0);
        run_one(0, 0);
        idle_step();
        chk("rsp_err_hold", rsp_err, 1);

        // Core2 read, last peer completes in the timeout cycle -> completion wins
        snp_done = 4'b1111;
        snp_hit  = 4'b0001;
        snp_data[0 +: 32] = 32'h77;
        expect_txn(2, 0);
        sb[sb.size()-1].lat = 16;
        snp_done = 4'b0011;
        req_valid = 4'b0100;
        run_one(0, 15);
        idle_step();

        // Reset in the middle of a core1 broadcast (rr=3 beforehand)
        snp_done  = 4'b0000;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_snoop_valid", snoop_valid, 1);
        rst = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk_all_zero("midrst");
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen = seen | (|rsp_valid);
        end
        chk("no_rsp_after_reset", seen, 0);

        // After reset rr is 0, so core1 wins over core3
        snp_done  = 4'b1111;
        snp_hit   = 4'b0000;
        req_valid = 4'b1010;
        expect_txn(1, 0);
        expect_txn(3, 1);
        run_one(0, 0);
        run_one(0, 0);
        idle_step();

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
